// File: rtl/ahb_burst_gen_if.sv
`timescale 1ns/1ps
// ahb_burst_gen_if
// AHB-Lite bus bundle between the burst generator (master) and a single
// slave such as bridge_top's AHB port.
//   haddr/hwrite/htrans/hburst/hsize : address phase control, master driven
//   hwdata                           : write data phase, master driven
//   hreadyin                         : ready fed back into the slave, master driven
//   hreadyout/hrdata/hresp           : slave ready, read data and response
interface ahb_burst_gen_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] haddr;
    logic [DATA_W-1:0] hwdata;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hburst;
    logic [2:0]        hsize;
    logic              hreadyin;
    logic              hreadyout;
    logic [DATA_W-1:0] hrdata;
    logic [1:0]        hresp;

    modport master (
        output haddr, hwdata, hwrite, htrans, hburst, hsize, hreadyin,
        input  hreadyout, hrdata, hresp
    );

    modport slave (
        input  haddr, hwdata, hwrite, htrans, hburst, hsize, hreadyin,
        output hreadyout, hrdata, hresp
    );
endinterface

// File: rtl/ahb_burst_gen.sv
`timescale 1ns/1ps
// ahb_burst_gen
// Command-driven AHB-Lite master. One start strobe launches a SINGLE,
// INCR4/8/16 or WRAP4/8/16 read or write burst; the engine handles wait
// states, the 1KB boundary rule for INCR bursts and two-cycle ERROR aborts.
//   hclk, hresetn            : clock (rising edge), asynchronous active-low reset
//   start, cmd_*             : command strobe and burst description (sampled in IDLE)
//   busy, done, err          : status; done/err are single-cycle pulses
//   rd_data, rd_valid        : captured read beat and its one-cycle strobe
//   ahb (master modport)     : AHB-Lite bus
module ahb_burst_gen #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              start,
    input  logic              cmd_write,
    input  logic [2:0]        cmd_burst,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    ahb_burst_gen_if.master   ahb
);
    localparam int         BYTES      = DATA_W / 8;
    localparam logic [2:0] HSIZE      = 3'($clog2(BYTES));
    localparam logic [1:0] TR_IDLE    = 2'b00;
    localparam logic [1:0] TR_NONSEQ  = 2'b10;
    localparam logic [1:0] TR_SEQ     = 2'b11;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_LAST, S_ABORT} state_t;

    state_t            state_q, state_n;
    logic [1:0]        htrans_q, htrans_n;
    logic [ADDR_W-1:0] haddr_q, haddr_n;
    logic [DATA_W-1:0] hwdata_q, hwdata_n;
    logic              hwrite_q, hwrite_n;
    logic [2:0]        hburst_q, hburst_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              err_q, err_n;
    logic [DATA_W-1:0] rd_data_q, rd_data_n;
    logic              rd_valid_q, rd_valid_n;
    logic [DATA_W-1:0] seed_q, seed_n;
    logic [4:0]        ic_q, ic_n;
    logic              dphase_q, dphase_n;

    logic [4:0]        num_beats;
    logic [4:0]        ic_inc;
    logic              is_wrap;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] next_addr;
    logic              crosses_1k;
    logic              error_first;

    function automatic logic [4:0] beats_of(input logic [2:0] burst);
        case (burst)
            3'b010, 3'b011: beats_of = 5'd4;
            3'b100, 3'b101: beats_of = 5'd8;
            3'b110, 3'b111: beats_of = 5'd16;
            default:        beats_of = 5'd1;
        endcase
    endfunction

    assign num_beats = beats_of(hburst_q);
    assign ic_inc    = ic_q + 5'd1;
    assign is_wrap   = (hburst_q == 3'b010) || (hburst_q == 3'b100) || (hburst_q == 3'b110);
    assign wrap_mask = ADDR_W'(32'(num_beats) * 32'(BYTES) - 32'd1);
    assign incr_addr = haddr_q + ADDR_W'(BYTES);
    // Wrapping keeps the bits above the burst window and cycles the offset inside it.
    assign next_addr = is_wrap ? ((haddr_q & ~wrap_mask) | (incr_addr & wrap_mask)) : incr_addr;
    // An INCR beat entering a new 1KB page must restart with NONSEQ.
    assign crosses_1k = !is_wrap && (haddr_q[ADDR_W-1:10] != incr_addr[ADDR_W-1:10]);
    // First cycle of a two-cycle ERROR response on an outstanding data phase.
    assign error_first = dphase_q && !ahb.hreadyout && (ahb.hresp == RESP_ERROR);

    always_comb begin
        state_n    = state_q;
        htrans_n   = htrans_q;
        haddr_n    = haddr_q;
        hwdata_n   = hwdata_q;
        hwrite_n   = hwrite_q;
        hburst_n   = hburst_q;
        busy_n     = busy_q;
        done_n     = 1'b0;
        err_n      = 1'b0;
        rd_data_n  = rd_data_q;
        rd_valid_n = 1'b0;
        seed_n     = seed_q;
        ic_n       = ic_q;
        dphase_n   = dphase_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_n  = S_BURST;
                    htrans_n = TR_NONSEQ;
                    haddr_n  = cmd_addr & ~ADDR_W'(BYTES - 1);
                    hwrite_n = cmd_write;
                    hburst_n = cmd_burst;
                    seed_n   = cmd_data;
                    ic_n     = 5'd0;
                    dphase_n = 1'b0;
                    busy_n   = 1'b1;
                end
            end
            S_BURST: begin
                if (error_first) begin
                    htrans_n = TR_IDLE;
                    state_n  = S_ABORT;
                end else if (ahb.hreadyout) begin
                    if (dphase_q && !hwrite_q && (ahb.hresp != RESP_ERROR)) begin
                        rd_data_n  = ahb.hrdata;
                        rd_valid_n = 1'b1;
                    end
                    // Beat ic's data phase starts now, so its write data is launched here.
                    if (hwrite_q) begin
                        hwdata_n = seed_q + DATA_W'(ic_q);
                    end
                    dphase_n = 1'b1;
                    ic_n     = ic_inc;
                    if (ic_inc < num_beats) begin
                        htrans_n = crosses_1k ? TR_NONSEQ : TR_SEQ;
                        haddr_n  = next_addr;
                    end else begin
                        htrans_n = TR_IDLE;
                        state_n  = S_LAST;
                    end
                end
            end
            S_LAST: begin
                if (error_first) begin
                    state_n = S_ABORT;
                end else if (ahb.hreadyout) begin
                    if (dphase_q && !hwrite_q && (ahb.hresp != RESP_ERROR)) begin
                        rd_data_n  = ahb.hrdata;
                        rd_valid_n = 1'b1;
                    end
                    dphase_n = 1'b0;
                    state_n  = S_IDLE;
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                end
            end
            S_ABORT: begin
                if (ahb.hreadyout) begin
                    dphase_n = 1'b0;
                    state_n  = S_IDLE;
                    done_n   = 1'b1;
                    err_n    = 1'b1;
                    busy_n   = 1'b0;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q    <= S_IDLE;
            htrans_q   <= TR_IDLE;
            haddr_q    <= '0;
            hwdata_q   <= '0;
            hwrite_q   <= 1'b0;
            hburst_q   <= 3'b000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            seed_q     <= '0;
            ic_q       <= 5'd0;
            dphase_q   <= 1'b0;
        end else begin
            state_q    <= state_n;
            htrans_q   <= htrans_n;
            haddr_q    <= haddr_n;
            hwdata_q   <= hwdata_n;
            hwrite_q   <= hwrite_n;
            hburst_q   <= hburst_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            err_q      <= err_n;
            rd_data_q  <= rd_data_n;
            rd_valid_q <= rd_valid_n;
            seed_q     <= seed_n;
            ic_q       <= ic_n;
            dphase_q   <= dphase_n;
        end
    end

    assign ahb.htrans   = htrans_q;
    assign ahb.haddr    = haddr_q;
    assign ahb.hwdata   = hwdata_q;
    assign ahb.hwrite   = hwrite_q;
    assign ahb.hburst   = hburst_q;
    assign ahb.hsize    = HSIZE;
    assign ahb.hreadyin = ahb.hreadyout;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
endmodule

// File: tb/tb_ahb_burst_gen.sv
`timescale 1ns/1ps
// tb_ahb_burst_gen
// Self-checking bench for ahb_burst_gen: a table of burst commands, each run
// against a responsive slave model with scoreboard queues for addresses,
// write data and read data, followed by reset-related hand sequences.
module tb_ahb_burst_gen;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              hclk = 1'b0;
    logic              hresetn;
    logic              start;
    logic              cmd_write;
    logic [2:0]        cmd_burst;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    ahb_burst_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ahb ();

    ahb_burst_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .start     (start),
        .cmd_write (cmd_write),
        .cmd_burst (cmd_burst),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .ahb       (ahb)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        bit          write;
        logic [2:0]  burst;
        logic [31:0] addr;
        logic [31:0] data;       // write seed, or read seed used by the slave model
        int          wait_beat;  // data beat that sees wait states (-1 none)
        int          wait_cycles;
        int          err_beat;   // data beat answered with ERROR (-1 none)
        bit          hold_start;
        int          exp_lat;    // cycles from first NONSEQ to done
        int          exp_rdv;
        bit          exp_err;
    } vec_t;

    vec_t        vecs[11];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] addr_q[$];
    logic [1:0]  trans_q[$];
    logic [31:0] wdata_q[$];
    logic [31:0] rdata_q[$];

    function automatic vec_t mk(bit w, logic [2:0] b, logic [31:0] a, logic [31:0] d, int wb, int wc,
                                int eb, bit hs, int lat, int rdv, bit e);
        vec_t v;
        v.write = w; v.burst = b; v.addr = a; v.data = d;
        v.wait_beat = wb; v.wait_cycles = wc; v.err_beat = eb; v.hold_start = hs;
        v.exp_lat = lat; v.exp_rdv = rdv; v.exp_err = e;
        return v;
    endfunction

    function automatic int beats_of(input logic [2:0] b);
        case (b)
            3'b011, 3'b010: return 4;
            3'b101, 3'b100: return 8;
            3'b111, 3'b110: return 16;
            default:        return 1;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int          n, size, cyc, ns_cycle, done_cycle, rd_count, done_count;
        int          data_idx, addr_idx, wait_left, err_state;
        bit          wrap, data_pend, hready;
        logic [31:0] base, blk, a, dummy;
        logic [1:0]  dummy_t;

        n    = beats_of(v.burst);
        wrap = (v.burst == 3'b010) || (v.burst == 3'b100) || (v.burst == 3'b110);
        base = v.addr & 32'hFFFF_FFFC;
        size = n * 4;
        blk  = base - (base % size);
        addr_q.delete(); trans_q.delete(); wdata_q.delete(); rdata_q.delete();
        for (int k = 0; k < n; k++) begin
            a = wrap ? blk + ((base - blk + k * 4) % size) : base + k * 4;
            addr_q.push_back(a);
            trans_q.push_back((k == 0 || (!wrap && a[9:0] == 10'd0)) ? 2'b10 : 2'b11);
            if (v.write) wdata_q.push_back(v.data + k);
            else if (v.err_beat < 0 || k < v.err_beat) rdata_q.push_back(v.data + k);
        end

        @(negedge hclk);
        start = 1'b1; cmd_write = v.write; cmd_burst = v.burst; cmd_addr = v.addr; cmd_data = v.data;
        ahb.hreadyout = 1'b1; ahb.hresp = 2'b00;
        cyc = 0; ns_cycle = -1; done_cycle = -1; rd_count = 0; done_count = 0;
        data_pend = 1'b0; data_idx = 0; addr_idx = 0; wait_left = v.wait_cycles; err_state = 0;

        while (cyc < 200 && done_count == 0) begin
            @(negedge hclk);
            if (!v.hold_start) start = 1'b0;
            if (ns_cycle < 0 && ahb.htrans == 2'b10) begin
                ns_cycle = cyc;
                checkOutput("busy_first_beat", 64'(busy), 64'(1));
            end
            if (rd_valid) begin
                rd_count++;
                if (rdata_q.size() > 0) begin
                    a = rdata_q.pop_front();
                    checkOutput("rd_data", 64'(rd_data), 64'(a));
                end
            end
            if (done) begin
                done_count++;
                done_cycle = cyc;
                start = 1'b0;
                checkOutput("err", 64'(err), 64'(v.exp_err));
                checkOutput("busy_at_done", 64'(busy), 64'(0));
            end else begin
                if (err_state == 1) checkOutput("htrans_after_error", 64'(ahb.htrans), 64'(0));
                if (ahb.htrans != 2'b00) begin
                    if (addr_q.size() > 0) begin
                        checkOutput("haddr", 64'(ahb.haddr), 64'(addr_q[0]));
                        checkOutput("htrans", 64'(ahb.htrans), 64'(trans_q[0]));
                        checkOutput("hburst", 64'(ahb.hburst), 64'(v.burst));
                        checkOutput("hwrite", 64'(ahb.hwrite), 64'(v.write));
                    end else begin
                        checkOutput("extra_address_phase", 64'(ahb.htrans), 64'(0));
                    end
                end
                if (data_pend && v.write && wdata_q.size() > 0)
                    checkOutput("hwdata", 64'(ahb.hwdata), 64'(wdata_q[0]));

                hready = 1'b1;
                ahb.hresp = 2'b00;
                ahb.hrdata = v.data + data_idx;
                if (data_pend && data_idx == v.err_beat) begin
                    ahb.hresp = 2'b01;
                    if (err_state == 0) begin
                        hready = 1'b0;
                        err_state = 1;
                    end else begin
                        err_state = 2;
                    end
                end else if (data_pend && data_idx == v.wait_beat && wait_left > 0) begin
                    hready = 1'b0;
                    wait_left--;
                end
                ahb.hreadyout = hready;
                if (hready) begin
                    if (data_pend && v.write && wdata_q.size() > 0) dummy = wdata_q.pop_front();
                    if (ahb.htrans != 2'b00 && addr_q.size() > 0) begin
                        dummy   = addr_q.pop_front();
                        dummy_t = trans_q.pop_front();
                        data_pend = 1'b1;
                        data_idx  = addr_idx;
                        addr_idx++;
                    end else begin
                        data_pend = 1'b0;
                    end
                end
            end
            cyc++;
        end

        checkOutput("done_count", 64'(done_count), 64'(1));
        checkOutput("latency", 64'(done_cycle - ns_cycle), 64'(v.exp_lat));
        checkOutput("rd_valid_count", 64'(rd_count), 64'(v.exp_rdv));
        if (v.err_beat >= 0) begin
            addr_q.delete(); trans_q.delete(); wdata_q.delete();
        end
        checkOutput("leftover_expectations", 64'(addr_q.size() + wdata_q.size() + rdata_q.size()), 64'(0));
        ahb.hreadyout = 1'b1;
        ahb.hresp = 2'b00;
        @(negedge hclk);
        checkOutput("done_pulse_width", 64'(done), 64'(0));
        checkOutput("idle_after_done", 64'(ahb.htrans), 64'(0));
    endtask

    initial begin
        bit seen_done;
        bit seen_trans;

        hresetn = 1'b0; start = 1'b0; cmd_write = 1'b0; cmd_burst = 3'b000;
        cmd_addr = '0; cmd_data = '0;
        ahb.hreadyout = 1'b1; ahb.hresp = 2'b00; ahb.hrdata = '0;

        repeat (2) @(negedge hclk);
        checkOutput("reset_htrans", 64'(ahb.htrans), 64'(0));
        checkOutput("reset_haddr", 64'(ahb.haddr), 64'(0));
        checkOutput("reset_hwdata", 64'(ahb.hwdata), 64'(0));
        checkOutput("reset_hwrite", 64'(ahb.hwrite), 64'(0));
        checkOutput("reset_hburst", 64'(ahb.hburst), 64'(0));
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        checkOutput("reset_err", 64'(err), 64'(0));
        checkOutput("reset_rd_valid", 64'(rd_valid), 64'(0));
        checkOutput("reset_rd_data", 64'(rd_data), 64'(0));
        checkOutput("hsize", 64'(ahb.hsize), 64'(2));
        ahb.hreadyout = 1'b0;
        #1 checkOutput("hreadyin_low", 64'(ahb.hreadyin), 64'(0));
        ahb.hreadyout = 1'b1;
        #1 checkOutput("hreadyin_high", 64'(ahb.hreadyin), 64'(1));
        @(negedge hclk);
        hresetn = 1'b1;

        //            wr    burst   addr           data           wb  wc  eb  hs  lat rdv err
        vecs[0]  = mk(1'b0, 3'b000, 32'h0000_0104, 32'h0000_00AB, -1, 0, -1, 0,  2,  1, 0);
        vecs[1]  = mk(1'b1, 3'b101, 32'h8000_0000, 32'h0000_0010, -1, 0, -1, 0,  9,  0, 0);
        vecs[2]  = mk(1'b0, 3'b100, 32'h8000_0034, 32'h0000_0200, -1, 0, -1, 0,  9,  8, 0);
        vecs[3]  = mk(1'b1, 3'b011, 32'h0000_03F8, 32'hFFFF_FFFE, -1, 0, -1, 0,  5,  0, 0);
        vecs[4]  = mk(1'b0, 3'b011, 32'h0000_1000, 32'h0000_0055,  2, 2, -1, 0,  7,  4, 0);
        vecs[5]  = mk(1'b0, 3'b101, 32'h0000_2000, 32'h0000_0070, -1, 0,  2, 0,  5,  2, 1);
        vecs[6]  = mk(1'b1, 3'b001, 32'h0000_0007, 32'h0000_0099, -1, 0, -1, 0,  2,  0, 0);
        vecs[7]  = mk(1'b1, 3'b010, 32'h0000_000C, 32'h0000_0020, -1, 0, -1, 1,  5,  0, 0);
        vecs[8]  = mk(1'b0, 3'b111, 32'h0000_03E0, 32'h0000_1000,  5, 1, -1, 0, 18, 16, 0);
        vecs[9]  = mk(1'b1, 3'b110, 32'h0000_007C, 32'h0000_0000, -1, 0, -1, 0, 17,  0, 0);
        vecs[10] = mk(1'b1, 3'b011, 32'h0000_0500, 32'h0000_0033, -1, 0,  0, 0,  3,  0, 1);

        for (int i = 0; i < 11; i++) begin
            $display("[TB] vector %0d: burst %0b addr 0x%0h write %0d", i, vecs[i].burst, vecs[i].addr, vecs[i].write);
            applyStimulus(vecs[i]);
        end

        $display("[TB] reset during an INCR8 write");
        @(negedge hclk);
        start = 1'b1; cmd_write = 1'b1; cmd_burst = 3'b101; cmd_addr = 32'h0000_3000; cmd_data = 32'h5;
        ahb.hreadyout = 1'b1; ahb.hresp = 2'b00;
        @(negedge hclk);
        start = 1'b0;
        checkOutput("mid_busy_before_reset", 64'(busy), 64'(1));
        repeat (2) @(negedge hclk);
        #2 hresetn = 1'b0;
        #1;
        checkOutput("mid_reset_htrans", 64'(ahb.htrans), 64'(0));
        checkOutput("mid_reset_busy", 64'(busy), 64'(0));
        checkOutput("mid_reset_haddr", 64'(ahb.haddr), 64'(0));
        checkOutput("mid_reset_hburst", 64'(ahb.hburst), 64'(0));
        seen_done = 1'b0;
        seen_trans = 1'b0;
        repeat (3) begin
            @(negedge hclk);
            if (done) seen_done = 1'b1;
        end
        hresetn = 1'b1;
        repeat (10) begin
            @(negedge hclk);
            if (done) seen_done = 1'b1;
            if (ahb.htrans != 2'b00) seen_trans = 1'b1;
        end
        checkOutput("no_done_after_reset", 64'(seen_done), 64'(0));
        checkOutput("no_transfer_after_reset", 64'(seen_trans), 64'(0));

        $display("[TB] recovery burst after reset");
        applyStimulus(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_burst_gen.md
Name: ahb_burst_gen

Overview:
- Synthesizable, parametrised AHB-Lite master transaction generator that drives bridge_top's AHB slave port.
- Replaces the fixed-width behavioural master tasks (single read/write, INCR8, WRAP8) with one command-driven engine.
- Supports SINGLE, INCR4/8/16 and WRAP4/8/16 bursts, read or write.
- Handles wait states, the 1KB boundary rule and ERROR responses.

Parameters:
ADDR_W, 32, haddr/cmd_addr width
DATA_W, 32, hwdata/hrdata width; legal values 8, 16, 32, 64
BYTES, DATA_W/8, derived; bytes per beat; hsize = log2(BYTES)

Ports:
hclk  in  1  clock, rising edge
hresetn  in  1  asynchronous active-low reset
start  in  1  command strobe, sampled only in IDLE
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_burst  in  3  AHB HBURST code: 000 SINGLE, 011 INCR4, 101 INCR8, 111 INCR16, 010 WRAP4, 100 WRAP8, 110 WRAP16; 001 treated as SINGLE
cmd_addr  in  ADDR_W  start address; low log2(BYTES) bits forced to 0
cmd_data  in  DATA_W  write seed; beat k data = cmd_data + k (mod 2^DATA_W)
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse at burst completion or abort
err  out  1  one-cycle pulse with done when the burst aborted on ERROR
rd_data  out  DATA_W  captured hrdata
rd_valid  out  1  one-cycle pulse per completed read beat
hreadyout  in  1  slave ready
hrdata  in  DATA_W  slave read data
hresp  in  2  00 OKAY, 01 ERROR
haddr  out  ADDR_W  address phase address
hwdata  out  DATA_W  data phase write data
hwrite  out  1  transfer direction
htrans  out  2  00 IDLE, 10 NONSEQ, 11 SEQ
hburst  out  3  echoes latched cmd_burst during the burst
hsize  out  3  constant log2(BYTES)
hreadyin  out  1  equals hreadyout combinationally (single-slave system)

Behaviour:
- Reset values (asynchronous, on hresetn low, including mid-burst):
  - htrans=00, haddr=0, hwdata=0, hwrite=0, hburst=000.
  - busy=0, done=0, err=0, rd_valid=0, rd_data=0.
  - FSM to IDLE; an in-flight burst is dropped with no done.
- FSM states: IDLE, BURST, LAST, ABORT.
- IDLE:
  - At a posedge with start=1: latch the command; beats N = 1/4/8/16 per cmd_burst.
  - Next cycle: htrans=NONSEQ, haddr=aligned cmd_addr, busy=1. Go to BURST.
  - start in any other state is ignored.
- BURST (pipelined): at each posedge with hreadyout=1:
  - The current address phase completes; issued count ic increments.
  - Any pending data phase completes; completed count dc increments.
  - If ic < N: next htrans=SEQ with the next address.
  - If ic reaches N: htrans=IDLE, haddr held, go to LAST.
  - With hreadyout=0, all address/control outputs and hwdata hold.
- Address arithmetic (mod 2^ADDR_W):
  - INCR: next = addr + BYTES. If the next address crosses a 1KB boundary (bits [ADDR_W-1:10] differ), that beat is NONSEQ instead of SEQ.
  - WRAP: mask = N*BYTES-1; next = (addr & ~mask) | ((addr + BYTES) & mask).
- Write data: hwdata = cmd_data + k during the data phase of beat k (the cycle after that beat's address phase is accepted).
- Read data: at a posedge with hreadyout=1 in a read data phase, register rd_data<=hrdata and pulse rd_valid for 1 cycle.
- LAST:
  - At the posedge with hreadyout=1: final data phase completes.
  - Next cycle: done=1, busy=0, FSM to IDLE.
  - SINGLE: 1 address cycle + ≥1 data cycle; done 2 cycles after the NONSEQ cycle with zero wait states.
- ERROR response:
  - When hresp=01 and hreadyout=0 during a data phase: at that posedge drive htrans=IDLE (cancel the pending beat) and go to ABORT.
  - ABORT waits for hreadyout=1, then pulses done=1 and err=1, busy=0, FSM to IDLE.
  - No rd_valid for the errored beat.
- Zero-wait-state latency: burst of N beats takes N+1 cycles from the first NONSEQ to the last data accept; done follows one cycle later.

Test Plan:
- Reset, then start SINGLE read, addr 0x0000_0104, hrdata=0x0000_00AB, no waits -> NONSEQ at 0x104; rd_valid once with rd_data=0xAB; done 2 cycles after NONSEQ; err=0.
- INCR8 write, addr 0x8000_0000, cmd_data=0x10 -> haddr 0x..00,04,…,1C; htrans NONSEQ then 7×SEQ; hwdata 0x10..0x17, each lagging its address by 1 cycle; done once.
- WRAP8 read, addr 0x8000_0034 -> haddr 0x34,38,3C,20,24,28,2C,30; 8 rd_valid pulses.
- INCR4 write from 0x0000_03F8 -> beats 0x3F8, 0x3FC (SEQ), 0x400 NONSEQ, 0x404 SEQ.
- INCR4 read with hreadyout low 2 cycles during beat 2 -> all outputs held those cycles; 4 rd_valid total; done one cycle after last accept.
- hresp=01 two-cycle ERROR on beat 3 of INCR8 -> htrans=IDLE next cycle, done+err pulse; 2 rd_valid. Second run: hresetn low mid-burst -> htrans=00, busy=0 immediately, no done.
